mem_access_stage: RTL
=====================

# mem_access_stage

Load/store unit for the MEM stage of the 64-bit RISC-V pipeline, sitting between the EX/MEM register and the MEM/WB register. It runs a req/ack handshake to a variable-latency data memory, builds byte enables and shifted store data, and sign- or zero-extends load data. It stalls the upstream pipeline until the access completes. Non-memory instructions pass through combinationally with zero added latency.

## Interface
- No parameters. Data width fixed at 64 bits, address width 64 bits, byte-enable width 8.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `valid_in` in 1: EX/MEM holds a valid instruction.
- `memread`, `memwrite` in 1 each: load or store requested (never both high).
- `regwrite`, `memtoreg` in 1 each: writeback controls from EX/MEM.
- `funct3` in 3: access size and signedness.
- `alures` in 64: effective address, or ALU result for non-memory ops.
- `writedata` in 64: store data, right-aligned.
- `RD` in 5: destination register.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `mem_addr` out 64: doubleword-aligned address (`addr[2:0]`=0).
- `mem_be` out 8: byte enables.
- `mem_wdata` out 64: lane-shifted store data.
- `mem_ack` in 1: memory completion.
- `mem_rdata` in 64: read doubleword, valid with `mem_ack`.
- `regwriteout`, `memtoregout` out 1 each: to MEM/WB.
- `aluresout` out 64: to MEM/WB.
- `readmem` out 64: formatted load data, to MEM/WB.
- `RDout` out 5: to MEM/WB.
- `stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `misalign_err` out 1: misaligned-access pulse (only with the macro in Configuration).

## Operation
- The block is a memory op when `valid_in & (memread | memwrite)`.
- Non-memory op:
  - `stall`=0.
  - Outputs equal their inputs combinationally.
  - `readmem`=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY on a memory op. Latch address, `funct3`, `writedata` and direction.
  - BUSY: `mem_req`=1 with stable `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`. On `mem_ack` sampled high, capture formatted `mem_rdata` (loads only), then → DONE.
  - DONE: present the result for one cycle, then → IDLE.
- `stall` = memory op & (state != DONE).
- While `stall`=1, `regwriteout` and `memtoregout` are forced to 0, so MEM/WB receives a bubble.
- In DONE, `regwriteout` and `memtoregout` follow their inputs and `readmem` holds the captured value.
- Access size from `funct3[1:0]`: 00 byte, 01 half, 10 word, 11 double. `funct3[2]`=1 selects zero-extension (LBU, LHU, LWU).
- `off` = `addr[2:0]`.
- `mem_be` = size mask (0x01, 0x03, 0x0F, 0xFF) << `off`.
- `mem_wdata` = `writedata` << (8·`off`).
- Load: shift `mem_rdata` >> (8·`off`), truncate to size, then sign- or zero-extend to 64 bits.
- Misaligned means `off` is not a multiple of the access size.
- `mem_ack` outside BUSY is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `mem_we`, `misalign_err` = 0.
  - `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - Captured load data = 0.
- Minimum memory-op latency is 3 cycles:
  - Cycle 0: accept, IDLE → BUSY, `stall`=1.
  - Cycle 1: `mem_req`=1; `mem_ack`=1 in this cycle → DONE.
  - Cycle 2: DONE, `stall`=0, result valid to MEM/WB.
- Each extra cycle of ack delay adds one stall cycle. There is no timeout.
- Upstream holds all inputs stable while `stall`=1.
- Back-to-back memory ops: DONE → IDLE → BUSY, so at least one IDLE cycle separates requests.
- Reset asserted in BUSY aborts the access: `mem_req` drops asynchronously and the captured data is discarded. Memory must tolerate a withdrawn request.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A misaligned memory op in IDLE issues no request.
  - `misalign_err` pulses high for 1 cycle, with `stall`=0 and `regwriteout`=0 that cycle.
  - State stays IDLE.
- Undefined:
  - `misalign_err` is tied to 0.
  - `addr` low bits are cleared to natural alignment before use and the access proceeds normally.

## Test plan
- ADD, `alures`=0x1234, `RD`=5 → same-cycle passthrough, `stall`=0, `regwriteout`=1, `RDout`=5.
- LB at 0x1003, `mem_rdata`=0x00000000_80000000, ack 1 cycle after req → `mem_be`=0x08, `readmem`=0xFFFFFFFF_FFFFFF80, `stall` high exactly 2 cycles.
- LBU with the same stimulus → `readmem`=0x80.
- SH at 0x2006, `writedata`=0xBEEF, ack after 4 cycles → `mem_we`=1, `mem_be`=0xC0, `mem_wdata`=0xBEEF0000_00000000, `stall` high 5 cycles, `regwriteout`=0 in DONE.
- LD at 0x0, reset asserted while BUSY → `mem_req`=0 immediately, state IDLE. A later ack is ignored and `readmem` stays 0.
- LW at 0x1002:
  - With `MISALIGN_TRAP_EN`: 1-cycle `misalign_err`, no `mem_req`.
  - Without: `mem_addr`=0x1000, `mem_be`=0x0F.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Brief    : RV64 MEM-stage load/store unit with req/ack data-memory handshake,
//             byte-lane store shifting and sign/zero-extended load formatting.
//             Optional macro MISALIGN_TRAP_EN: trap misaligned accesses instead
//             of force-aligning them.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        regwrite,
    input  logic        memtoreg,
    input  logic [2:0]  funct3,
    input  logic [63:0] alures,
    input  logic [63:0] writedata,
    input  logic [4:0]  RD,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        regwriteout,
    output logic        memtoregout,
    output logic [63:0] aluresout,
    output logic [63:0] readmem,
    output logic [4:0]  RDout,
    output logic        stall,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  be_q, be_d;
    logic [63:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] rdata_q, rdata_d;

    logic        w_mem_op;
    logic [2:0]  w_mask;
    logic        w_trap;
    logic [63:0] w_eff_addr;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic [63:0] w_shift;
    logic [63:0] w_fmt;

    assign w_mem_op = valid_in & (memread | memwrite);

    // Low address bits that must be zero for a naturally aligned access.
    always_comb begin
        case (funct3[1:0])
            2'b00:   w_mask = 3'b000;
            2'b01:   w_mask = 3'b001;
            2'b10:   w_mask = 3'b011;
            default: w_mask = 3'b111;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_trap     = w_mem_op & (state_q == S_IDLE) & (|(alures[2:0] & w_mask));
    assign w_eff_addr = alures;
`else
    assign w_trap     = 1'b0;
    assign w_eff_addr = {alures[63:3], alures[2:0] & ~w_mask};
`endif

    always_comb begin
        case (funct3[1:0])
            2'b00:   w_be = 8'h01 << w_eff_addr[2:0];
            2'b01:   w_be = 8'h03 << w_eff_addr[2:0];
            2'b10:   w_be = 8'h0F << w_eff_addr[2:0];
            default: w_be = 8'hFF;
        endcase
    end

    assign w_wdata = writedata << {w_eff_addr[2:0], 3'b000};

    // Load formatting uses the latched offset/size so it stays valid while BUSY.
    assign w_shift = mem_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   w_fmt = {{56{~funct3_q[2] & w_shift[7]}},  w_shift[7:0]};
            2'b01:   w_fmt = {{48{~funct3_q[2] & w_shift[15]}}, w_shift[15:0]};
            2'b10:   w_fmt = {{32{~funct3_q[2] & w_shift[31]}}, w_shift[31:0]};
            default: w_fmt = w_shift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (w_mem_op && !w_trap) begin
                    state_d  = S_BUSY;
                    we_d     = memwrite;
                    addr_d   = w_eff_addr;
                    be_d     = w_be;
                    wdata_d  = w_wdata;
                    funct3_d = funct3;
                    rdata_d  = 64'd0;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    if (!we_q) rdata_d = w_fmt;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= 64'd0;
            be_q     <= 8'd0;
            wdata_q  <= 64'd0;
            funct3_q <= 3'd0;
            rdata_q  <= 64'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_req      = (state_q == S_BUSY);
    assign mem_we       = we_q;
    assign mem_addr     = {addr_q[63:3], 3'b000};
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;

    assign stall        = w_mem_op & (state_q != S_DONE) & ~w_trap;
    assign misalign_err = w_trap;

    // A stalled or trapped instruction becomes a bubble in MEM/WB.
    assign regwriteout  = regwrite & ~stall & ~w_trap;
    assign memtoregout  = memtoreg & ~stall & ~w_trap;
    assign aluresout    = alures;
    assign RDout        = RD;
    assign readmem      = (w_mem_op && (state_q == S_DONE)) ? rdata_q : 64'd0;

endmodule
`default_nettype wire
